// File: rtl/control_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: opcodes, datapath selects,
// branch condition codes and the sequencer state encoding.
package control_pkg;

   typedef enum logic [1:0] {
      S_FETCH = 2'b00,
      S_EXEC  = 2'b01,
      S_MEM   = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_D    = 3'd2,
      IMM_B    = 3'd3,
      IMM_CB   = 3'd4
   } imm_t;

   // 11-bit opcodes, IR[31:21]
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_BR   = 11'b11010110000;

   // 10-bit immediate opcodes, IR[31:22]
   localparam logic [9:0] OP_ADDI  = 10'b1001000100;
   localparam logic [9:0] OP_ADDIS = 10'b1011000100;
   localparam logic [9:0] OP_SUBI  = 10'b1101000100;
   localparam logic [9:0] OP_SUBIS = 10'b1111000100;

   localparam logic [5:0] OP_B     = 6'b000101;    // IR[31:26]
   localparam logic [7:0] OP_BCOND = 8'b01010100;  // IR[31:24]

   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_EOR = 5'b01100;
   localparam logic [4:0] FS_SUB = 5'b01001;

   localparam logic [2:0] DS_ALU = 3'b000;
   localparam logic [2:0] DS_B   = 3'b001;
   localparam logic [2:0] DS_PC  = 3'b010;
   localparam logic [2:0] DS_MEM = 3'b011;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_LOAD = 2'b10;
   localparam logic [1:0] PS_REL  = 2'b11;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   function automatic logic cond_taken(input logic [3:0] cond, input logic v,
                                       input logic n, input logic z);
      case (cond)
         COND_EQ: cond_taken = z;
         COND_NE: cond_taken = !z;
         COND_GE: cond_taken = (n == v);
         COND_LT: cond_taken = (n != v);
         COND_GT: cond_taken = !z && (n == v);
         COND_LE: cond_taken = z || (n != v);
         COND_AL: cond_taken = 1'b1;
         default: cond_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/control_imm_gen.sv
// Builds the 64-bit constant K from the low 26 instruction bits for the selected
// immediate format; zero when no immediate is selected.
module control_imm_gen (
   input  logic [25:0] ir_imm,
   input  logic [2:0]  imm_sel,
   output logic [63:0] k
);
   import control_pkg::*;

   always_comb begin
      k = '0;
      case (imm_t'(imm_sel))
         IMM_I:   k = {52'd0, ir_imm[21:10]};
         IMM_D:   k = {{55{ir_imm[20]}}, ir_imm[20:12]};
         IMM_B:   k = {{38{ir_imm[25]}}, ir_imm[25:0]};
         IMM_CB:  k = {{45{ir_imm[23]}}, ir_imm[23:5]};
         default: k = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle LEGv8 sequencer: FETCH -> EXEC (-> MEM for loads), with a sticky HALT.
// Only the state is registered; every control output decodes from state, IR_Out and SF.
module control_unit #(
   parameter int PC_STEP       = 4,
   parameter bit HALT_ON_UNDEF = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IR_Out,
   input  logic [3:0]  SF,
   output logic        AS,
   output logic [2:0]  DS,
   output logic [1:0]  PS,
   output logic        PC_Sel,
   output logic        K_Sel,
   output logic        IL,
   output logic        SL,
   output logic [4:0]  FS,
   output logic        C0,
   output logic        MW,
   output logic        RW,
   output logic [4:0]  DA,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [63:0] K,
   output logic        halt
);
   import control_pkg::*;

   state_t      state, next_state;
   imm_t        imm_sel;
   logic [10:0] op;
   logic [4:0]  rd, rn, rm;
   logic        alu_r, alu_i, alu_sub, alu_flags;
   logic [4:0]  alu_fs;

   // The PC increment lives in program_counter; the carry flag has no consumer here.
   logic [7:0]  unused_pc_step;
   logic        unused_carry;
   assign unused_pc_step = 8'(PC_STEP);
   assign unused_carry   = SF[2];

   assign op = IR_Out[31:21];
   assign rd = IR_Out[4:0];
   assign rn = IR_Out[9:5];
   assign rm = IR_Out[20:16];

   assign alu_r     = op inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR};
   assign alu_i     = op[10:1] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS};
   assign alu_sub   = (op inside {OP_SUB, OP_SUBS}) || (op[10:1] inside {OP_SUBI, OP_SUBIS});
   assign alu_flags = (op inside {OP_ADDS, OP_SUBS}) || (op[10:1] inside {OP_ADDIS, OP_SUBIS});

   always_comb begin
      alu_fs = FS_ADD;
      if (alu_sub)          alu_fs = FS_SUB;
      else if (op == OP_AND) alu_fs = FS_AND;
      else if (op == OP_ORR) alu_fs = FS_ORR;
      else if (op == OP_EOR) alu_fs = FS_EOR;
   end

   control_imm_gen u_imm_gen (
      .ir_imm  (IR_Out[25:0]),
      .imm_sel (imm_sel),
      .k       (K)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= next_state;
   end

   // Everything is forced quiet while rst is high so a reset mid-instruction
   // cannot leak a write enable.
   always_comb begin
      next_state = state;
      imm_sel    = IMM_NONE;
      AS = 1'b0;  DS = DS_ALU;  PS = PS_HOLD;  PC_Sel = 1'b0;  K_Sel = 1'b0;
      IL = 1'b0;  SL = 1'b0;    FS = FS_AND;   C0 = 1'b0;      MW = 1'b0;
      RW = 1'b0;  DA = '0;      SA = '0;       SB = '0;        halt = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               AS = 1'b1;  DS = DS_MEM;  IL = 1'b1;
               next_state = S_EXEC;
            end
            S_EXEC: begin
               next_state = S_FETCH;
               if (alu_r || alu_i) begin
                  SA = rn;  SB = rm;  DA = rd;  DS = DS_ALU;  RW = 1'b1;  PS = PS_INC;
                  FS = alu_fs;  C0 = alu_sub;  SL = alu_flags;
                  if (alu_i) begin
                     K_Sel = 1'b1;  imm_sel = IMM_I;
                  end
               end else if (op == OP_LDUR || op == OP_STUR) begin
                  SA = rn;  FS = FS_ADD;  K_Sel = 1'b1;  imm_sel = IMM_D;
                  if (op == OP_LDUR) begin
                     DS = DS_MEM;
                     next_state = S_MEM;
                  end else begin
                     SB = rd;  DS = DS_B;  MW = 1'b1;  PS = PS_INC;
                  end
               end else if (IR_Out[31:26] == OP_B) begin
                  imm_sel = IMM_B;  PC_Sel = 1'b1;  PS = PS_REL;
               end else if (IR_Out[31:24] == OP_BCOND) begin
                  imm_sel = IMM_CB;  PC_Sel = 1'b1;
                  PS = cond_taken(IR_Out[3:0], SF[3], SF[1], SF[0]) ? PS_REL : PS_INC;
               end else if (op == OP_BR) begin
                  SA = rn;  PS = PS_LOAD;
               end else if (HALT_ON_UNDEF) begin
                  next_state = S_HALT;
               end else begin
                  PS = PS_INC;
               end
            end
            S_MEM: begin
               SA = rn;  FS = FS_ADD;  K_Sel = 1'b1;  imm_sel = IMM_D;  DS = DS_MEM;
               DA = rd;  RW = 1'b1;  PS = PS_INC;
               next_state = S_FETCH;
            end
            default: begin
               halt = 1'b1;
            end
         endcase
      end
   end

endmodule
